f2i_arbiter: RTL and testbench
==============================

# f2i_arbiter

Shares one combinational `float_to_integer` converter between two requesters. It arbitrates round-robin, registers the converted result with its exception flags and the winning requester's ID, and holds the result until the consumer takes it. It also keeps sticky exception flags per requester and a saturating conversion counter. It sits between the FPU issue logic and the integer writeback path.

## Interface
- `CNT_W`, default 16, width of the saturating conversion counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has an operand.
- `req0_a` in 32: requester 0's IEEE-754 single-precision operand.
- `req0_ready` out 1: requester 0's operand is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_ready`: same set of signals for requester 1.
- `resp_valid` out 1: the result register holds a valid result.
- `resp_ready` in 1: the consumer takes the result this cycle.
- `resp_id` out 1: index of the requester that owns the result.
- `resp_d` out 32: converted integer.
- `resp_p_lost` out 1: precision-lost flag for the result.
- `resp_denorm` out 1: denormal-input flag for the result.
- `resp_invalid` out 1: invalid-conversion flag for the result.
- `flags0` out 3: sticky flags for requester 0, as {invalid, denorm, p_lost}.
- `flags1` out 3: sticky flags for requester 1, same packing.
- `clr_flags0` in 1: synchronous clear of `flags0`.
- `clr_flags1` in 1: synchronous clear of `flags1`.
- `conv_count` out CNT_W: number of accepted conversions; saturates at all-ones.

## Operation
- One `float_to_integer` instance, `(a, d, p_lost, denorm, invalid)`. Its `a` input is muxed from the granted requester's operand.
- Result register states:
  - EMPTY, with `resp_valid`=0.
  - FULL, with `resp_valid`=1.
- `accept_ok` = EMPTY, or FULL with `resp_ready`=1 (pass-through drain).
- Grant:
  - Exactly one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - The last-grant pointer updates only on an actual acceptance.
- `reqN_ready` = `accept_ok` and requester N wins. It is combinational from `reqN_valid`, the pointer and state.
  - The loser's ready is 0.
  - Both readies are 0 when `accept_ok`=0.
- On acceptance:
  - The result register loads `d`, the three flags and `resp_id`=winner.
  - The state becomes or stays FULL.
- FULL with `resp_ready`=1 and no acceptance: the state becomes EMPTY.
- FULL with `resp_ready`=0: all `resp_*` outputs hold stable.
- Sticky flags:
  - On acceptance, `flagsN` |= the new flags for winner N.
  - `clr_flagsN` clears `flagsN`. If a set and a clear hit the same cycle, the new flags win; the old value is cleared.
- `conv_count` increments on every acceptance and holds at 2^CNT_W-1.

## Timing
- Reset (`clrn`=0) forces asynchronously:
  - State EMPTY.
  - `resp_valid`=0, `resp_id`=0, `resp_d`=0, all `resp_*` flags 0.
  - `flags0`=`flags1`=0, `conv_count`=0.
  - Last-grant pointer=1, so requester 0 wins the first tie.
- Reset mid-operation discards a held result. It is not redelivered.
- Latency: operand accepted at edge N, so `resp_valid`=1 with its result after edge N.
- Throughput: one conversion per cycle while `resp_ready`=1.
- Alternation under continuous dual requests: 0,1,0,1…
- Requesters hold `reqN_a` stable while `reqN_valid`=1 and `reqN_ready`=0. `resp_ready` may toggle freely.

## Test plan
- Reset, then `req0_a`=0x3f800000 alone → `req0_ready`=1; next cycle `resp_valid`=1, `resp_id`=0, `resp_d`=1, flags 000, `conv_count`=1.
- `req1_a`=0x3fc00000, then 0x7f800000 → `resp_d`=1 with `resp_p_lost`=1, then `resp_invalid`=1. `flags1`=3'b101 and `flags0` is unchanged.
- Both valid for 4 cycles with `resp_ready`=1 → grants 0,1,0,1, `resp_id` sequence 0,1,0,1, `conv_count`=4.
- Hold `resp_ready`=0 with a result FULL → both readies are 0 and `resp_*` are stable for 5 cycles. Raising `resp_ready` drains the result and accepts the next operand in the same cycle.
- Requester 0 sends 0x00000001 while `clr_flags0`=1 in its acceptance cycle → `flags0` = exactly the flags from this conversion (`denorm`=1), not ORed with older bits.
- Assert `clrn` while FULL → `resp_valid` drops immediately and all outputs read 0. Set CNT_W=2 and run 5 conversions → `conv_count` saturates at 3.

Source files
------------

// File: rtl/f2i_arbiter.sv
// ----------------------------------------------------------------------------
// f2i_arbiter
//
// Shares one combinational float_to_integer converter between two requesters.
// Requests are arbitrated round-robin. The converted integer, its exception
// flags and the winning requester's ID are captured in a result register.
// That register is held until the consumer takes it. The block also keeps
// per-requester sticky exception flags and a saturating count of accepted
// conversions.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A requester holds its operand stable while valid=1 and ready=0.
// reqN_ready is combinational from the valids, the last-grant pointer and
// the result-register state. resp_ready may change freely; a FULL register
// with resp_ready=1 can drain and reload in the same cycle.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   req0_valid/req0_a/req0_ready  requester 0 operand handshake
//   req1_valid/req1_a/req1_ready  requester 1 operand handshake
//   resp_valid/resp_ready     result handshake
//   resp_id                   requester that owns the result
//   resp_d                    converted signed 32-bit integer
//   resp_p_lost/denorm/invalid  exception flags for the result
//   flags0/flags1             sticky {invalid, denorm, p_lost} per requester
//   clr_flags0/clr_flags1     synchronous clears of the sticky flags
//   conv_count                accepted conversions, saturating at all-ones
// ----------------------------------------------------------------------------

// float_to_integer
// Converts an IEEE-754 single to a signed 32-bit integer, truncating toward
// zero.
//   zero          -> d=0, no flags
//   denormal      -> d=0, denorm=1, p_lost=1 (a nonzero value became 0)
//   |a| < 1       -> d=0, p_lost=1
//   out of range, inf or NaN -> d=32'h80000000, invalid=1
//   exactly -2^31 -> d=32'h80000000, no flags
//   otherwise     -> d = truncated value, p_lost=1 when fraction bits drop
module float_to_integer (
  input  logic [31:0] a,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        denorm,
  output logic        invalid
);
  logic        sign;
  logic [7:0]  expo;
  logic [22:0] frac;
  logic        is_zero;
  logic [7:0]  shift_r;
  logic [55:0] frac0;
  logic [55:0] f_abs;
  logic [31:0] mag;

  assign sign    = a[31];
  assign expo    = a[30:23];
  assign frac    = a[22:0];
  assign denorm  = (expo == 8'd0) && (frac != 23'd0);
  assign is_zero = (expo == 8'd0) && (frac == 23'd0);
  // Hidden bit at bit 55. After shifting right by 158-exp, bits [55:24]
  // hold the integer part and bits [23:0] hold the dropped fraction.
  assign frac0   = {1'b1, frac, 32'd0};
  assign shift_r = 8'd158 - expo;

  always_comb begin
    d       = 32'd0;
    p_lost  = 1'b0;
    invalid = 1'b0;
    f_abs   = 56'd0;
    mag     = 32'd0;
    if (denorm) begin
      p_lost = 1'b1;
    end else if (is_zero) begin
      d = 32'd0;
    end else if ((expo > 8'd158) ||
                 ((expo == 8'd158) && !(sign && (frac == 23'd0)))) begin
      // |a| >= 2^31, except exactly -2^31 which still fits.
      invalid = 1'b1;
      d       = 32'h8000_0000;
    end else if (expo < 8'd127) begin
      p_lost = 1'b1;
    end else begin
      f_abs  = frac0 >> shift_r;
      mag    = f_abs[55:24];
      p_lost = |f_abs[23:0];
      d      = sign ? (~mag + 32'd1) : mag;
    end
  end
endmodule

module f2i_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_d,
  output logic             resp_p_lost,
  output logic             resp_denorm,
  output logic             resp_invalid,
  output logic [2:0]       flags0,
  output logic [2:0]       flags1,
  input  logic             clr_flags0,
  input  logic             clr_flags1,
  output logic [CNT_W-1:0] conv_count
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic        last_grant;
  logic        accept_ok;
  logic        winner;
  logic        accept;
  logic [31:0] conv_a;
  logic [31:0] conv_d;
  logic        conv_p_lost;
  logic        conv_denorm;
  logic        conv_invalid;
  logic [2:0]  new_flags;

  always_comb begin
    accept_ok = (state == EMPTY) || resp_ready;
    // On a tie the requester not granted last wins; otherwise the only
    // valid requester wins (winner is don't-care when neither is valid).
    if (req0_valid && req1_valid) winner = ~last_grant;
    else                          winner = req1_valid;
    accept = accept_ok && (req0_valid || req1_valid);
  end

  assign req0_ready = accept && !winner;
  assign req1_ready = accept && winner;
  assign conv_a     = winner ? req1_a : req0_a;
  assign resp_valid = (state == FULL);
  assign new_flags  = {conv_invalid, conv_denorm, conv_p_lost};

  float_to_integer u_f2i (
    .a       (conv_a),
    .d       (conv_d),
    .p_lost  (conv_p_lost),
    .denorm  (conv_denorm),
    .invalid (conv_invalid)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state        <= EMPTY;
      last_grant   <= 1'b1;
      resp_id      <= 1'b0;
      resp_d       <= 32'd0;
      resp_p_lost  <= 1'b0;
      resp_denorm  <= 1'b0;
      resp_invalid <= 1'b0;
      flags0       <= 3'b000;
      flags1       <= 3'b000;
      conv_count   <= '0;
    end else begin
      if (accept) begin
        state        <= FULL;
        last_grant   <= winner;
        resp_id      <= winner;
        resp_d       <= conv_d;
        resp_p_lost  <= conv_p_lost;
        resp_denorm  <= conv_denorm;
        resp_invalid <= conv_invalid;
        if (conv_count != {CNT_W{1'b1}}) conv_count <= conv_count + CNT_W'(1);
      end else if ((state == FULL) && resp_ready) begin
        state <= EMPTY;
      end
      // A clear drops the old bits only; flags from this cycle's conversion
      // still land.
      flags0 <= (clr_flags0 ? 3'b000 : flags0) |
                ((accept && !winner) ? new_flags : 3'b000);
      flags1 <= (clr_flags1 ? 3'b000 : flags1) |
                ((accept && winner) ? new_flags : 3'b000);
    end
  end
endmodule

// File: tb/tb_f2i_arbiter.sv
module tb_f2i_arbiter;
  logic        clk;
  logic        clrn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req1_a;
  logic        resp_ready;
  logic        clr_flags0, clr_flags1;

  logic        req0_ready, req1_ready, resp_valid, resp_id;
  logic [31:0] resp_d;
  logic        resp_p_lost, resp_denorm, resp_invalid;
  logic [2:0]  flags0, flags1;
  logic [15:0] conv_count;

  logic        s_req0_ready, s_req1_ready, s_resp_valid, s_resp_id;
  logic [31:0] s_resp_d;
  logic        s_resp_p_lost, s_resp_denorm, s_resp_invalid;
  logic [2:0]  s_flags0, s_flags1;
  logic [1:0]  s_conv_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_full;
  bit          m_last;
  logic [31:0] m_d;
  bit          m_id;
  logic [2:0]  m_fl;
  logic [2:0]  m_f0, m_f1;
  int          m_cnt;
  bit          last_acc0, last_acc1;

  f2i_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_d(resp_d), .resp_p_lost(resp_p_lost), .resp_denorm(resp_denorm),
    .resp_invalid(resp_invalid), .flags0(flags0), .flags1(flags1),
    .clr_flags0(clr_flags0), .clr_flags1(clr_flags1), .conv_count(conv_count)
  );

  f2i_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .clrn(clrn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_ready(s_req1_ready),
    .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_id(s_resp_id),
    .resp_d(s_resp_d), .resp_p_lost(s_resp_p_lost), .resp_denorm(s_resp_denorm),
    .resp_invalid(s_resp_invalid), .flags0(s_flags0), .flags1(s_flags1),
    .clr_flags0(clr_flags0), .clr_flags1(clr_flags1), .conv_count(s_conv_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Conversion rules computed directly from the numeric value of the float.
  function automatic void ref_f2i(input logic [31:0] a, output logic [31:0] d,
                                  output logic [2:0] fl);
    int     e;
    longint m, mag;
    bit     lost;
    e  = int'(a[30:23]);
    m  = longint'({1'b1, a[22:0]});
    d  = 32'd0;
    fl = 3'b000;
    mag  = 0;
    lost = 1'b0;
    if (e == 0) begin
      if (a[22:0] != 23'd0) fl = 3'b011;
    end else if (e >= 159) begin
      d  = 32'h8000_0000;
      fl = 3'b100;
    end else begin
      if (e < 127) begin
        mag = 0; lost = 1'b1;
      end else if (e <= 150) begin
        mag  = m >> (150 - e);
        lost = (m & ((64'sd1 << (150 - e)) - 64'sd1)) != 0;
      end else begin
        mag = m << (e - 150);
      end
      if (mag > 64'sd2147483648 || (mag == 64'sd2147483648 && !a[31])) begin
        d  = 32'h8000_0000;
        fl = 3'b100;
      end else begin
        d  = a[31] ? 32'(-mag) : 32'(mag);
        fl = {2'b00, lost};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    k = $urandom_range(0, 9);
    r = $urandom;
    case (k)
      0:       r = r & 32'h8000_0000;
      1:       r = (r & 32'h807f_ffff) | 32'h1;
      2:       r = {r[31], 8'hff, r[22:0]};
      3:       r = 32'hcf00_0000;
      4:       r = {r[31], 8'd158, r[22:0]};
      default: r = {r[31], 8'($urandom_range(120, 160)), r[22:0]};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_full = 0; m_last = 1; m_d = 0; m_id = 0; m_fl = 0;
    m_f0 = 0; m_f1 = 0; m_cnt = 0; last_acc0 = 0; last_acc1 = 0;
  endtask

  // One clock: readies checked at the falling edge, registered outputs #1
  // after the rising edge.
  task automatic cycle();
    bit ok, w, acc;
    logic [31:0] cd;
    logic [2:0]  cf;
    @(negedge clk);
    ok = !m_full || resp_ready;
    if (req0_valid && req1_valid) w = !m_last;
    else                          w = req1_valid;
    acc = ok && (req0_valid || req1_valid);
    check("req0_ready", 32'(req0_ready), 32'(acc && !w));
    check("req1_ready", 32'(req1_ready), 32'(acc && w));
    check("sat_readies", 32'({s_req0_ready, s_req1_ready}), 32'({acc && !w, acc && w}));
    ref_f2i(w ? req1_a : req0_a, cd, cf);
    if (clr_flags0) m_f0 = 3'b000;
    if (clr_flags1) m_f1 = 3'b000;
    last_acc0 = acc && !w;
    last_acc1 = acc && w;
    if (acc) begin
      m_full = 1; m_last = w; m_id = w; m_d = cd; m_fl = cf; m_cnt++;
      if (w) m_f1 |= cf; else m_f0 |= cf;
    end else if (m_full && resp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    check("resp_valid", 32'(resp_valid), 32'(m_full));
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("resp_d", resp_d, m_d);
    check("resp_flags", 32'({resp_invalid, resp_denorm, resp_p_lost}), 32'(m_fl));
    check("flags0", 32'(flags0), 32'(m_f0));
    check("flags1", 32'(flags1), 32'(m_f1));
    check("conv_count", 32'(conv_count), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check("sat_count", 32'(s_conv_count), 32'((m_cnt > 3) ? 3 : m_cnt));
    check("sat_outputs",
          {s_resp_d[23:0], s_resp_valid, s_resp_id, s_resp_invalid, s_resp_denorm,
           s_resp_p_lost, s_flags0[0], s_flags1[0], 1'b0},
          {m_d[23:0], m_full, m_id, m_fl, m_f0[0], m_f1[0], 1'b0});
  endtask

  initial begin
    clrn = 0; req0_valid = 0; req1_valid = 0; req0_a = 0; req1_a = 0;
    resp_ready = 0; clr_flags0 = 0; clr_flags1 = 0;
    model_reset();

    // Reset state
    #3;
    check("rst_resp", 32'({resp_valid, resp_id, resp_p_lost, resp_denorm, resp_invalid}), 32'd0);
    check("rst_d", resp_d, 32'd0);
    check("rst_flags_cnt", 32'({flags0, flags1, conv_count}), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk); clrn = 1;
    @(posedge clk); #1;

    // First conversion: 1.0 from requester 0
    req0_valid = 1; req0_a = 32'h3f80_0000; resp_ready = 1;
    cycle();
    check("first_d", resp_d, 32'd1);
    check("first_id_flags", 32'({resp_valid, resp_id, resp_invalid, resp_denorm, resp_p_lost}), 32'b10000);
    check("first_count", 32'(conv_count), 32'd1);

    // Requester 1: 1.5 then +inf
    req0_valid = 0; req1_valid = 1; req1_a = 32'h3fc0_0000;
    cycle();
    check("r1_1p5", {resp_d[30:0], resp_p_lost}, {31'd1, 1'b1});
    req1_a = 32'h7f80_0000;
    cycle();
    check("r1_inf", 32'(resp_invalid), 32'd1);
    check("flags1_101", 32'(flags1), 32'b101);
    check("flags0_same", 32'(flags0), 32'b000);

    // Continuous dual requests alternate 0,1,0,1
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_a = rand_op(); req1_a = rand_op();
      cycle();
      check("alt_id", 32'(resp_id), 32'(i % 2));
    end

    // Consumer stall for 5 cycles, then drain and accept in the same cycle
    resp_ready = 0;
    req0_a = rand_op(); req1_a = rand_op();
    for (int i = 0; i < 5; i++) cycle();
    resp_ready = 1;
    cycle();

    // Set/clear collision on flags0
    req1_valid = 0; req0_valid = 1; req0_a = 32'h3fc0_0000;
    cycle();
    req0_a = 32'h0000_0001; clr_flags0 = 1;
    cycle();
    clr_flags0 = 0;
    check("clr_set_flags0", 32'(flags0), 32'b011);
    check("denorm_d", resp_d, 32'd0);

    // Randomized traffic honouring the operand-hold rule
    for (int i = 0; i < 200; i++) begin
      if (!req0_valid || last_acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0); req0_a = rand_op();
      end
      if (!req1_valid || last_acc1) begin
        req1_valid = ($urandom_range(0, 3) != 0); req1_a = rand_op();
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      clr_flags0 = ($urandom_range(0, 9) == 0);
      clr_flags1 = ($urandom_range(0, 9) == 0);
      cycle();
    end
    clr_flags0 = 0; clr_flags1 = 0;

    // Reset while FULL
    resp_ready = 0; req0_valid = 1; req1_valid = 0; req0_a = 32'h4000_0000;
    cycle();
    req0_valid = 0;
    #2 clrn = 0;
    #1;
    model_reset();
    check("midrst_resp", 32'({resp_valid, resp_id, resp_p_lost, resp_denorm, resp_invalid}), 32'd0);
    check("midrst_d", resp_d, 32'd0);
    check("midrst_flags_cnt", 32'({flags0, flags1, conv_count, s_conv_count}), 32'd0);
    @(negedge clk); clrn = 1;
    @(posedge clk); #1;
    cycle();
    check("no_redeliver", 32'(resp_valid), 32'd0);

    // Saturation of the 2-bit counter over 6 conversions
    resp_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req0_a = rand_op(); req1_a = rand_op();
      cycle();
    end
    check("sat_at_3", 32'(s_conv_count), 32'd3);
    check("count_6", 32'(conv_count), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
